// File: rtl/c7bbiu_ifill_pkg.sv
`default_nettype none
// ============================================================================
// Module  : c7b_biu_pkg
// Brief   : Shared types and bus encodings for the BIU instruction-fill path.
// Revision: 1.0 - initial release
// ============================================================================
package c7b_biu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_LAST = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_64    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LINE_LEN   = 8'd3;

endpackage
`default_nettype wire

// File: rtl/c7bbiu_ifill_if.sv
`default_nettype none
// ============================================================================
// Module  : c7bbiu_ifill_if
// Brief   : Read-address / read-data bus between the fill engine and memory.
// Revision: 1.0 - initial release
// ============================================================================
interface c7bbiu_ifill_if #(
    parameter int ADDR_W = 32
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;

    logic              r_valid;
    logic              r_ready;
    logic [63:0]       r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last
    );
endinterface
`default_nettype wire

// File: rtl/c7bbiu_ifill.sv
`default_nettype none
// ============================================================================
// Module  : c7bbiu_ifill
// Brief   : Instruction-cache fill engine: one line (or single beat) per request.
// Revision: 1.0 - initial release
// ============================================================================
module c7bbiu_ifill
    import c7b_biu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              icu_biu_req,
    input  logic [28:0]       icu_biu_addr,
    input  logic              icu_biu_single,
    output logic              biu_icu_ack,
    output logic              biu_icu_data_valid,
    output logic              biu_icu_data_last,
    output logic [63:0]       biu_icu_data,
    output logic              biu_icu_fault,

    c7bbiu_ifill_if.master    bus
);

    localparam int c_CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    state_t               r_state;
    logic [28:0]          r_addr;
    logic                 r_single;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_error;
    logic                 r_ar_valid;
    logic                 r_r_ready;
    logic                 r_data_valid;
    logic                 r_data_last;
    logic                 r_fault;
    logic [63:0]          r_data;

    logic                 w_accept;
    logic [7:0]           w_ar_len;
    logic [31:0]          w_byte_addr;
    logic                 w_beat;
    logic                 w_cnt_hit;
    logic                 w_term;
    logic                 w_error_nxt;

    assign w_accept    = icu_biu_req & (r_state == ST_IDLE) & ~reset;
    assign w_ar_len    = r_single ? 8'd0 : LINE_LEN;
    // Line fills are aligned to the 32-byte line; singles keep the beat address.
    assign w_byte_addr = r_single ? {r_addr, 3'b000} : {r_addr[28:2], 5'b00000};

    assign w_beat      = bus.r_valid & r_r_ready;
    assign w_cnt_hit   = (8'(r_count) == w_ar_len);
    assign w_term      = bus.r_last | w_cnt_hit;
    // A beat is in error on a bad response or when r_last disagrees with the count.
    assign w_error_nxt = r_error | (bus.r_resp != RESP_OKAY) | (bus.r_last != w_cnt_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_single     <= 1'b0;
            r_count      <= '0;
            r_error      <= 1'b0;
            r_ar_valid   <= 1'b0;
            r_r_ready    <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_fault      <= 1'b0;
            r_data       <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_fault      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= icu_biu_addr;
                        r_single   <= icu_biu_single;
                        r_count    <= '0;
                        r_error    <= 1'b0;
                        r_ar_valid <= 1'b1;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        r_data_valid <= 1'b1;
                        r_data       <= bus.r_data;
                        r_count      <= r_count + c_CNT_W'(1);
                        r_error      <= w_error_nxt;
                        if (w_term) begin
                            r_data_last <= 1'b1;
                            r_fault     <= w_error_nxt;
                            r_r_ready   <= 1'b0;
                            r_state     <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign biu_icu_ack        = w_accept;
    assign biu_icu_data_valid = r_data_valid;
    assign biu_icu_data_last  = r_data_last;
    assign biu_icu_fault      = r_fault;
    assign biu_icu_data       = r_data;

    assign bus.ar_valid = r_ar_valid;
    assign bus.ar_addr  = ADDR_W'(w_byte_addr);
    assign bus.ar_len   = w_ar_len;
    assign bus.ar_size  = SIZE_64;
    assign bus.ar_burst = BURST_INCR;
    assign bus.r_ready  = r_r_ready;

endmodule
`default_nettype wire

// File: tb/tb_c7bbiu_ifill.sv
`default_nettype none
// ============================================================================
// Module  : tb_c7bbiu_ifill
// Brief   : Directed scoreboard bench for the instruction-fill engine.
// Revision: 1.0 - initial release
// ============================================================================
module tb_c7bbiu_ifill;

    logic        clk = 1'b0;
    logic        reset;
    logic        icu_biu_req;
    logic [28:0] icu_biu_addr;
    logic        icu_biu_single;
    logic        biu_icu_ack;
    logic        biu_icu_data_valid;
    logic        biu_icu_data_last;
    logic [63:0] biu_icu_data;
    logic        biu_icu_fault;

    c7bbiu_ifill_if #(.ADDR_W(32)) bus ();

    c7bbiu_ifill #(.ADDR_W(32), .LINE_BEATS(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .icu_biu_req        (icu_biu_req),
        .icu_biu_addr       (icu_biu_addr),
        .icu_biu_single     (icu_biu_single),
        .biu_icu_ack        (biu_icu_ack),
        .biu_icu_data_valid (biu_icu_data_valid),
        .biu_icu_data_last  (biu_icu_data_last),
        .biu_icu_data       (biu_icu_data),
        .biu_icu_fault      (biu_icu_fault),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        fault;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every forwarded beat must match the next scoreboard entry.
    always @(negedge clk) begin
        if (biu_icu_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_data",  biu_icu_data,            mon_e.data);
                chk("beat_last",  64'(biu_icu_data_last),  64'(mon_e.last));
                chk("beat_fault", 64'(biu_icu_fault),      64'(mon_e.fault));
            end
        end else if (reset === 1'b0) begin
            chk("last_fault_wo_valid", 64'({biu_icu_data_last, biu_icu_fault}), 64'd0);
        end
    end

    task automatic accept(input logic [28:0] a, input logic s);
        icu_biu_req    = 1'b1;
        icu_biu_addr   = a;
        icu_biu_single = s;
        #1;
        chk("ack_idle", 64'(biu_icu_ack), 64'd1);
        tick;
        icu_biu_req = 1'b0;
        #1;
        chk("ack_addr", 64'(biu_icu_ack), 64'd0);
    endtask

    task automatic addr_phase(input logic [31:0] exp_addr, input logic [7:0] exp_len, input int delay);
        chk("ar_valid", 64'(bus.ar_valid), 64'd1);
        chk("ar_addr",  64'(bus.ar_addr),  64'(exp_addr));
        chk("ar_len",   64'(bus.ar_len),   64'(exp_len));
        chk("ar_size",  64'(bus.ar_size),  64'd3);
        chk("ar_burst", 64'(bus.ar_burst), 64'd1);
        for (int k = 0; k < delay; k++) begin
            tick;
            chk("ar_valid_hold", 64'(bus.ar_valid), 64'd1);
            chk("ar_addr_hold",  64'(bus.ar_addr),  64'(exp_addr));
        end
        bus.ar_ready = 1'b1;
        tick;
        bus.ar_ready = 1'b0;
        chk("ar_valid_drop", 64'(bus.ar_valid), 64'd0);
    endtask

    // Drives beats until the fill ends by r_last or by the beat count.
    task automatic data_phase(input bit single, input int rlast_at, input int err_beat, input int gaps);
        int          len;
        int          cnt;
        bit          err;
        bit          term;
        bit          lst;
        bit          hit;
        logic [63:0] d;
        len  = single ? 0 : 3;
        cnt  = 0;
        err  = 1'b0;
        term = 1'b0;
        while (!term) begin
            if (gaps[cnt]) begin
                bus.r_valid = 1'b0;
                tick;
            end
            chk("r_ready_data", 64'(bus.r_ready), 64'd1);
            d   = {$urandom, $urandom};
            lst = (cnt == rlast_at);
            hit = (cnt == len);
            term = lst || hit;
            err  = err || (cnt == err_beat) || (lst != hit);
            bus.r_valid = 1'b1;
            bus.r_data  = d;
            bus.r_last  = lst;
            bus.r_resp  = (cnt == err_beat) ? 2'b10 : 2'b00;
            sb.push_back('{data: d, last: term, fault: term && err});
            tick;
            chk("ack_busy", 64'(biu_icu_ack), 64'd0);
            cnt++;
        end
        bus.r_valid = 1'b0;
        bus.r_last  = 1'b0;
        bus.r_resp  = 2'b00;
        chk("r_ready_last", 64'(bus.r_ready), 64'd0);
        tick;
        chk("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        reset          = 1'b1;
        icu_biu_req    = 1'b0;
        icu_biu_addr   = '0;
        icu_biu_single = 1'b0;
        bus.ar_ready   = 1'b0;
        bus.r_valid    = 1'b0;
        bus.r_data     = '0;
        bus.r_resp     = 2'b00;
        bus.r_last     = 1'b0;
        repeat (2) tick;
        chk("rst_ack",      64'(biu_icu_ack),        64'd0);
        chk("rst_valid",    64'(biu_icu_data_valid), 64'd0);
        chk("rst_last",     64'(biu_icu_data_last),  64'd0);
        chk("rst_fault",    64'(biu_icu_fault),      64'd0);
        chk("rst_data",     biu_icu_data,            64'd0);
        chk("rst_ar_valid", 64'(bus.ar_valid),       64'd0);
        chk("rst_r_ready",  64'(bus.r_ready),        64'd0);
        reset = 1'b0;
        tick;

        // Line fill from byte 0x1234
        accept(29'h246, 1'b0);
        addr_phase(32'h0000_1220, 8'd3, 0);
        data_phase(1'b0, 3, -1, 0);

        // Single fill at 0x4008
        accept(29'h801, 1'b1);
        addr_phase(32'h0000_4008, 8'd0, 0);
        data_phase(1'b1, 0, -1, 0);

        // SLVERR on beat 1
        accept(29'h1000, 1'b0);
        addr_phase(32'h0000_8000, 8'd3, 0);
        data_phase(1'b0, 3, 1, 0);

        // Early r_last on the second beat
        accept(29'h0A04, 1'b0);
        addr_phase(32'h0000_5020, 8'd3, 0);
        data_phase(1'b0, 1, -1, 0);

        // Missing r_last, with gaps before beats 1 and 3
        accept(29'h0C0F, 1'b0);
        addr_phase(32'h0000_6060, 8'd3, 0);
        data_phase(1'b0, -1, -1, 4'b1010);

        // Back-to-back: next request held across the whole first fill
        accept(29'h0400, 1'b0);
        addr_phase(32'h0000_2000, 8'd3, 3);
        icu_biu_req    = 1'b1;
        icu_biu_addr   = 29'h0600;
        icu_biu_single = 1'b1;
        data_phase(1'b0, 3, -1, 0);
        accept(29'h0600, 1'b1);
        addr_phase(32'h0000_3000, 8'd0, 0);
        data_phase(1'b1, 0, -1, 0);

        // Reset during DATA after one beat
        accept(29'h0800, 1'b0);
        addr_phase(32'h0000_4000, 8'd3, 0);
        d = {$urandom, $urandom};
        bus.r_valid = 1'b1;
        bus.r_data  = d;
        bus.r_last  = 1'b0;
        bus.r_resp  = 2'b00;
        sb.push_back('{data: d, last: 1'b0, fault: 1'b0});
        tick;
        bus.r_valid = 1'b0;
        reset = 1'b1;
        tick;
        chk("mid_rst_valid",    64'(biu_icu_data_valid), 64'd0);
        chk("mid_rst_last",     64'(biu_icu_data_last),  64'd0);
        chk("mid_rst_fault",    64'(biu_icu_fault),      64'd0);
        chk("mid_rst_data",     biu_icu_data,            64'd0);
        chk("mid_rst_ar_valid", 64'(bus.ar_valid),       64'd0);
        chk("mid_rst_r_ready",  64'(bus.r_ready),        64'd0);
        reset = 1'b0;
        tick;
        chk("mid_rst_sb", 64'(sb.size()), 64'd0);

        // Recovery fill after reset
        accept(29'h0123, 1'b1);
        addr_phase(32'h0000_0918, 8'd0, 1);
        data_phase(1'b1, 0, -1, 0);

        repeat (2) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
